video_ctrl_top: RTL and testbench

- Top-level of the SoCFPGA video controller, run from the 50 MHz board clock.
- Generates VGA-style timing (HSYNC, VSYNC, BLANK) and a test-pattern RGB stream on the video interface, sized by HDISP×VDISP.
- Drives status LEDs and presents the hardware-support interface in an idle state.
- Single clock domain; all logic uses one synchronous active-high reset.

---
 rtl/video_ctrl_top.sv | 154 +++++++++++++++
 tb/tb_video_ctrl_top.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/video_ctrl_top.sv
// rtl/video_ctrl_top.sv - VGA-style timing and grid test-pattern video controller top
//
// Purpose: generates HSYNC/VSYNC/BLANK timing and a 16-pixel grid test pattern
// from the 50 MHz board clock, drives status LEDs, and holds the
// hardware-support bridge idle.
//
// Ports:
//   FPGA_CLK1_50   in   1   sole clock (also the pixel clock)
//   KEY            in   2   push buttons, active-low; KEY[0] = reset, KEY[1] unused
//   SW             in   4   switches, mirrored on LED[5:2]
//   LED            out  8   {2'b00, SW registered, blink, rst}
//   o_hws_*        out      hardware-support bridge requests, held inactive
//   i_hws_*        in       hardware-support bridge responses, ignored
//   o_video_clk    out  1   pixel clock (FPGA_CLK1_50 forwarded)
//   o_video_hs     out  1   horizontal sync, active-low
//   o_video_vs     out  1   vertical sync, active-low
//   o_video_blank  out  1   1 in the active picture region
//   o_video_rgb    out  24  pixel colour, black outside the active region
module video_ctrl_top #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int HFP        = 40,
  parameter int HPULSE     = 48,
  parameter int HBP        = 40,
  parameter int VFP        = 13,
  parameter int VPULSE     = 3,
  parameter int VBP        = 29,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic        FPGA_CLK1_50,
  input  logic [1:0]  KEY,
  input  logic [3:0]  SW,
  output logic [7:0]  LED,
  output logic        o_hws_req,
  output logic        o_hws_we,
  output logic [31:0] o_hws_addr,
  output logic [31:0] o_hws_wdata,
  input  logic [31:0] i_hws_rdata,
  input  logic        i_hws_ack,
  output logic        o_video_clk,
  output logic        o_video_hs,
  output logic        o_video_vs,
  output logic        o_video_blank,
  output logic [23:0] o_video_rgb
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int XW     = $clog2(HTOTAL);
  localparam int YW     = $clog2(VTOTAL);
  localparam int BW     = $clog2(BLINK_HALF + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(HTOTAL - 1);
  localparam logic [XW-1:0] X_ACT_END = XW'(HDISP);
  localparam logic [XW-1:0] X_HS_BEG  = XW'(HDISP + HFP);
  localparam logic [XW-1:0] X_HS_END  = XW'(HDISP + HFP + HPULSE);
  localparam logic [YW-1:0] Y_LAST    = YW'(VTOTAL - 1);
  localparam logic [YW-1:0] Y_ACT_END = YW'(VDISP);
  localparam logic [YW-1:0] Y_VS_BEG  = YW'(VDISP + VFP);
  localparam logic [YW-1:0] Y_VS_END  = YW'(VDISP + VFP + VPULSE);
  localparam logic [BW-1:0] B_LAST    = BW'(BLINK_HALF - 1);

  // Reset button synchronizer; its second stage is the block-wide reset.
  // These two flops are the reset source, so they carry no reset themselves.
  logic [1:0]    r_key_sync;
  logic          w_rst;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic [23:0]   r_rgb;
  logic [BW-1:0] r_blink_cnt;
  logic          r_led1;
  logic [3:0]    r_sw;

  logic          w_active;
  logic          w_hsync;
  logic          w_vsync;
  logic          w_grid;
  logic          w_unused;

  always_ff @(posedge FPGA_CLK1_50) begin
    r_key_sync <= {r_key_sync[0], ~KEY[0]};
  end

  assign w_rst = r_key_sync[1];

  // Raster counters: y advances only on the clock where x wraps.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (w_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (r_x == X_LAST) begin
      r_x <= '0;
      r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
    end else begin
      r_x <= r_x + 1'b1;
    end
  end

  assign w_active = (r_x < X_ACT_END) && (r_y < Y_ACT_END);
  assign w_hsync  = (r_x >= X_HS_BEG) && (r_x < X_HS_END);
  assign w_vsync  = (r_y >= Y_VS_BEG) && (r_y < Y_VS_END);
  assign w_grid   = (r_x[3:0] == 4'd0) || (r_y[3:0] == 4'd0);

  // All video outputs share the same single register stage so they stay aligned.
  always_ff @(posedge FPGA_CLK1_50) begin
    if (w_rst) begin
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b0;
      r_rgb   <= 24'h000000;
    end else begin
      r_hs    <= ~w_hsync;
      r_vs    <= ~w_vsync;
      r_blank <= w_active;
      r_rgb   <= (w_active && w_grid) ? 24'hFFFFFF : 24'h000000;
    end
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    if (w_rst) begin
      r_blink_cnt <= '0;
      r_led1      <= 1'b0;
      r_sw        <= 4'd0;
    end else begin
      r_sw <= SW;
      if (r_blink_cnt == B_LAST) begin
        r_blink_cnt <= '0;
        r_led1      <= ~r_led1;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign LED           = {2'b00, r_sw, r_led1, w_rst};

  assign o_video_clk   = FPGA_CLK1_50;
  assign o_video_hs    = r_hs;
  assign o_video_vs    = r_vs;
  assign o_video_blank = r_blank;
  assign o_video_rgb   = r_rgb;

  assign o_hws_req     = 1'b0;
  assign o_hws_we      = 1'b0;
  assign o_hws_addr    = 32'd0;
  assign o_hws_wdata   = 32'd0;

  assign w_unused      = &{1'b0, KEY[1], i_hws_rdata, i_hws_ack};

endmodule

// File: tb/tb_video_ctrl_top.sv
// tb/tb_video_ctrl_top.sv - self-checking bench for video_ctrl_top at 160x90
module tb_video_ctrl_top;

  localparam int HT       = 288;
  localparam int FRAME    = 38880;
  localparam int BLINK    = 10;

  logic        clk;
  logic [1:0]  key;
  logic [3:0]  sw;
  logic [7:0]  led;
  logic        hws_req;
  logic        hws_we;
  logic [31:0] hws_addr;
  logic [31:0] hws_wdata;
  logic        vclk;
  logic        vhs;
  logic        vvs;
  logic        vblank;
  logic [23:0] vrgb;

  int          checks;
  int          errors;
  logic [3:0]  sw_exp;
  logic [34:0] sb_q[$];

  video_ctrl_top #(
    .HDISP(160), .VDISP(90),
    .HFP(40), .HPULSE(48), .HBP(40),
    .VFP(13), .VPULSE(3), .VBP(29),
    .BLINK_HALF(BLINK)
  ) dut (
    .FPGA_CLK1_50 (clk),
    .KEY          (key),
    .SW           (sw),
    .LED          (led),
    .o_hws_req    (hws_req),
    .o_hws_we     (hws_we),
    .o_hws_addr   (hws_addr),
    .o_hws_wdata  (hws_wdata),
    .i_hws_rdata  (32'hDEAD_BEEF),
    .i_hws_ack    (1'b1),
    .o_video_clk  (vclk),
    .o_video_hs   (vhs),
    .o_video_vs   (vvs),
    .o_video_blank(vblank),
    .o_video_rgb  (vrgb)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {HS, VS, BLANK, RGB, LED} for the k-th clock after the first
  // non-reset edge; position in the frame is derived from the 160x90 timing.
  function automatic logic [34:0] expect_at(input int k, input logic [3:0] s);
    int         p;
    int         x;
    int         y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       l1;
    logic [23:0] rgb;
    p   = k % FRAME;
    x   = p % HT;
    y   = p / HT;
    hs  = !(x >= 200 && x < 248);
    vs  = !(y >= 103 && y < 106);
    bl  = (x < 160) && (y < 90);
    rgb = (bl && ((x % 16) == 0 || (y % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
    l1  = (((k + 1) / BLINK) % 2) == 1;
    return {hs, vs, bl, rgb, 2'b00, s, l1, 1'b0};
  endfunction

  task automatic sb_run(input int k0, input int k1, input bit meas);
    logic [34:0] got;
    logic [34:0] e;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
    logic        phs;
    logic        pbl;
    int          y;
    int          l0_blank, l0_hs_low, hs_first, hs_second;
    int          vs_low, vs_first, vb_blank, leak, w1, b1, w16, frame_rise;
    phs = 1'b1; pbl = 1'b0;
    l0_blank = 0; l0_hs_low = 0; hs_first = -1; hs_second = -1;
    vs_low = 0; vs_first = -1; vb_blank = 0; leak = 0;
    w1 = 0; b1 = 0; w16 = 0; frame_rise = -1;
    for (int k = k0; k <= k1; k++) begin
      sb_q.push_back(expect_at(k, sw_exp));
      tick();
      got = {vhs, vvs, vblank, vrgb, led};
      e   = sb_q.pop_front();
      chk($sformatf("pixel_k%0d", k), 64'(got), 64'(e));
      hs = got[34]; vs = got[33]; bl = got[32]; rgb = got[31:8];
      if (meas) begin
        y = k / HT;
        if (k < FRAME) begin
          if (y == 0 && bl) l0_blank++;
          if (y == 0 && !hs) l0_hs_low++;
          if (!hs && hs_first < 0) hs_first = k;
          if (phs && !hs && k >= HT && hs_second < 0) hs_second = k;
          if (!vs) begin
            vs_low++;
            if (vs_first < 0) vs_first = k;
          end
          if (y >= 90 && bl) vb_blank++;
          if (!bl && rgb != 24'h0) leak++;
          if (y == 1 && bl && rgb == 24'hFFFFFF) w1++;
          if (y == 1 && bl && rgb == 24'h000000) b1++;
          if (y == 16 && bl && rgb == 24'hFFFFFF) w16++;
        end
        if (!pbl && bl && k >= 90 * HT && frame_rise < 0) frame_rise = k;
      end
      phs = hs;
      pbl = bl;
    end
    if (meas) begin
      chk("line0_blank_clocks", 64'(l0_blank), 64'd160);
      chk("hs_start", 64'(hs_first), 64'd200);
      chk("hs_low_clocks", 64'(l0_hs_low), 64'd48);
      chk("line_period", 64'(hs_second - hs_first), 64'd288);
      chk("vs_start", 64'(vs_first), 64'd29664);
      chk("vs_low_clocks", 64'(vs_low), 64'd864);
      chk("vblank_blank", 64'(vb_blank), 64'd0);
      chk("rgb_leak", 64'(leak), 64'd0);
      chk("line1_white", 64'(w1), 64'd10);
      chk("line1_black", 64'(b1), 64'd150);
      chk("line16_white", 64'(w16), 64'd160);
      chk("frame_period", 64'(frame_rise), 64'd38880);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    key    = 2'b11;
    sw     = 4'b1010;
    sw_exp = 4'b1010;
    repeat (3) tick();

    // Power-on reset pulse: KEY[0] low for 128 ns.
    key[0] = 1'b0;
    tick();
    chk("rst_not_yet", 64'(led[0]), 64'd0);
    tick();
    chk("rst_asserted", 64'(led[0]), 64'd1);
    #88;
    chk("reset_video", 64'({vhs, vvs, vblank, vrgb}), 64'({1'b1, 1'b1, 1'b0, 24'h0}));
    chk("reset_led", 64'(led), 64'h01);
    chk("hws_idle", 64'({hws_req, hws_we}), 64'd0);
    chk("hws_idle_bus", {hws_addr, hws_wdata}, 64'd0);
    chk("vclk_high", 64'(vclk), 64'(clk));
    key[0] = 1'b1;
    tick();
    chk("rst_hold", 64'(led[0]), 64'd1);
    tick();
    chk("rst_released", 64'(led[0]), 64'd0);

    // First full frame plus the first pixel of the next, then run into frame 2.
    sb_run(0, FRAME, 1'b1);
    sb_run(FRAME + 1, FRAME + 5000, 1'b0);

    // Mid-frame reset while inside the active region.
    key[0] = 1'b0;
    tick();
    tick();
    tick();
    chk("midreset_video", 64'({vhs, vvs, vblank, vrgb}), 64'({1'b1, 1'b1, 1'b0, 24'h0}));
    chk("midreset_led", 64'(led), 64'h01);
    tick();
    key[0] = 1'b1;
    tick();
    tick();
    chk("midreset_released", 64'(led[0]), 64'd0);
    sb_run(0, FRAME, 1'b1);

    // Switch mirror: registered, so unchanged until the next edge.
    sw     = 4'b0101;
    #1;
    chk("sw_before_edge", 64'(led[5:2]), 64'b1010);
    tick();
    chk("sw_after_edge", 64'(led[5:2]), 64'b0101);
    chk("led_top_zero", 64'(led[7:6]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
